// File: rtl/riscv_sp_pkg.sv
// Shared types for the single-pipe core's instruction-side line protocol.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_sp_pkg;

    localparam int ICACHE_LINE_W = 128;
    localparam int IC_CNT_W      = 4;

    typedef logic [ICACHE_LINE_W-1:0] icache_line_t;

    typedef enum logic [1:0] {
        IC_IDLE,
        IC_WAIT,
        IC_RESP
    } icache_srv_state_t;

endpackage

// File: rtl/icache_line_rom.sv
// Read-only LINES x 128-bit line array, zero-filled at start.
// Latency: combinational read; the parent registers the result.
// Backpressure: none, a line is available every cycle.
module icache_line_rom
    import riscv_sp_pkg::*;
#(
    parameter int    LINES     = 64,
    parameter string INIT_FILE = "",
    localparam int   IDX_W     = $clog2(LINES)
) (
    input  logic [IDX_W-1:0] idx,
    output icache_line_t     line
);

    icache_line_t mem [LINES];

    initial begin
        for (int i = 0; i < LINES; i++) begin
            mem[i] = '0;
        end
    end

    assign line = mem[idx];

endmodule

// File: rtl/icache_line_server.sv
// Responder for fetch-queue line reads: one 128-bit line per accepted rd_en.
// Latency: dout_valid pulses RD_LATENCY cycles after the accepting edge.
// Backpressure: rd_en ignored while busy; abort drops an in-flight read until RESP.
module icache_line_server
    import riscv_sp_pkg::*;
#(
    parameter int    LINES      = 64,
    parameter int    RD_LATENCY = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [31:0]        pc_in,
    input  logic               rd_en,
    input  logic               abort,
    output logic [127:0]       dout,
    output logic               dout_valid,
    output logic               busy
);

    localparam int IDX_W = $clog2(LINES);
    localparam logic [IC_CNT_W-1:0] CNT_LOAD = IC_CNT_W'(RD_LATENCY - 1);

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
            $fatal(1, "icache_line_server: RD_LATENCY must be in 1..15");
        end
    endgenerate

    icache_srv_state_t   state, next_state;
    logic [IC_CNT_W-1:0] cnt, next_cnt;
    logic [IDX_W-1:0]    idx_q, next_idx;
    logic [IDX_W-1:0]    pc_idx;
    logic                accept;
    icache_line_t        rom_line;
    logic                unused_pc;

    // Upper address bits are dropped so addresses wrap modulo LINES.
    assign pc_idx    = pc_in[4 +: IDX_W];
    assign unused_pc = ^{pc_in[31:4+IDX_W], pc_in[3:0]};
    assign accept    = rd_en & ~abort;
    assign busy      = (state == IC_WAIT);

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_idx   = idx_q;
        case (state)
            IC_IDLE, IC_RESP: begin
                if (accept) begin
                    next_idx   = pc_idx;
                    next_cnt   = CNT_LOAD;
                    next_state = (RD_LATENCY == 1) ? IC_RESP : IC_WAIT;
                end else begin
                    next_state = IC_IDLE;
                end
            end
            IC_WAIT: begin
                next_cnt = cnt - 1'b1;
                if (abort) begin
                    next_state = IC_IDLE;
                end else if (cnt == 1) begin
                    next_state = IC_RESP;
                end
            end
            default: begin
                next_state = IC_IDLE;
            end
        endcase
    end

    // Addressed by next_idx so a latency-1 request reads the line it is entering RESP with.
    icache_line_rom #(
        .LINES     (LINES),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .idx  (next_idx),
        .line (rom_line)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IC_IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            idx_q      <= next_idx;
            dout_valid <= (next_state == IC_RESP);
            if (next_state == IC_RESP) begin
                dout <= rom_line;
            end
        end
    end

endmodule

// File: tb/tb_icache_line_server.sv
// Directed bench for icache_line_server at RD_LATENCY 4 and 1.
module tb_icache_line_server;
    import riscv_sp_pkg::*;

    localparam logic [127:0] L0 = 128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D;
    localparam logic [127:0] L1 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] L2 = 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF;
    localparam logic [127:0] L5 = 128'h0000006F_00000013_00A00093_00500113;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pc4, pc1;
    logic         rd4, rd1, ab4, ab1;
    logic [127:0] dout4, dout1;
    logic         dv4, dv1, busy4, busy1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    icache_line_server #(.LINES(64), .RD_LATENCY(4), .INIT_FILE("")) dut4 (
        .i_clk(clk), .i_rst(rst), .pc_in(pc4), .rd_en(rd4), .abort(ab4),
        .dout(dout4), .dout_valid(dv4), .busy(busy4)
    );

    icache_line_server #(.LINES(64), .RD_LATENCY(1), .INIT_FILE("")) dut1 (
        .i_clk(clk), .i_rst(rst), .pc_in(pc1), .rd_en(rd1), .abort(ab1),
        .dout(dout1), .dout_valid(dv1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One latency-4 read on dut4: accept edge, three waiting edges, then the pulse.
    task automatic req4(input string tag, input logic [31:0] pc, input logic [127:0] exp);
        pc4 = pc;
        rd4 = 1'b1;
        tick();
        rd4 = 1'b0;
        chk({tag, "_busy"}, 128'(busy4), 128'd1);
        tick();
        chk({tag, "_dv_t1"}, 128'(dv4), 128'd0);
        tick();
        chk({tag, "_dv_t2"}, 128'(dv4), 128'd0);
        tick();
        chk({tag, "_dv_t3"}, 128'(dv4), 128'd1);
        chk({tag, "_dout"}, dout4, exp);
        chk({tag, "_busy_resp"}, 128'(busy4), 128'd0);
        tick();
        chk({tag, "_dv_after"}, 128'(dv4), 128'd0);
        chk({tag, "_dout_hold"}, dout4, exp);
    endtask

    initial begin
        dut4.u_rom.mem[0] = L0;
        dut4.u_rom.mem[1] = L1;
        dut4.u_rom.mem[2] = L2;
        dut4.u_rom.mem[5] = L5;
        dut1.u_rom.mem[0] = L0;
        dut1.u_rom.mem[1] = L1;
        dut1.u_rom.mem[5] = L5;

        rst = 1'b1;
        pc4 = '0; rd4 = 1'b0; ab4 = 1'b0;
        pc1 = '0; rd1 = 1'b0; ab1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_dout4", dout4, '0);
        chk("rst_dv4", 128'(dv4), 128'd0);
        chk("rst_busy4", 128'(busy4), 128'd0);
        chk("rst_dout1", dout1, '0);
        chk("rst_dv1", 128'(dv1), 128'd0);

        // Basic read of line 5.
        req4("rd_line5", 32'h0000_0050, L5);

        // Abort two edges after accept: no response ever, busy drops.
        pc4 = 32'h0000_0000;
        rd4 = 1'b1;
        tick();
        rd4 = 1'b0;
        tick();
        ab4 = 1'b1;
        tick();
        ab4 = 1'b0;
        chk("abort_busy", 128'(busy4), 128'd0);
        for (int k = 0; k < 8; k++) begin
            chk("abort_no_dv", 128'(dv4), 128'd0);
            tick();
        end
        chk("abort_dout_hold", dout4, L5);

        // Back-to-back: second request held through WAIT, accepted in RESP.
        pc4 = 32'h0000_0000;
        rd4 = 1'b1;
        tick();
        pc4 = 32'h0000_0010;
        tick();
        chk("b2b_dv_a1", 128'(dv4), 128'd0);
        tick();
        chk("b2b_dv_a2", 128'(dv4), 128'd0);
        tick();
        chk("b2b_dv_a", 128'(dv4), 128'd1);
        chk("b2b_dout_a", dout4, L0);
        tick();
        rd4 = 1'b0;
        chk("b2b_dv_gap", 128'(dv4), 128'd0);
        chk("b2b_busy_b", 128'(busy4), 128'd1);
        tick();
        tick();
        chk("b2b_dv_b2", 128'(dv4), 128'd0);
        tick();
        chk("b2b_dv_b", 128'(dv4), 128'd1);
        chk("b2b_dout_b", dout4, L1);
        tick();
        chk("b2b_idle", 128'(dv4), 128'd0);

        // Low nibble ignored, then upper bits wrap modulo LINES.
        req4("nibble", 32'h0000_005F, L5);
        req4("wrap", 32'h0000_0410, L1);

        // Reset in the middle of a read.
        pc4 = 32'h0000_0020;
        rd4 = 1'b1;
        tick();
        rd4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_dv", 128'(dv4), 128'd0);
        chk("mid_rst_dout", dout4, '0);
        chk("mid_rst_busy", 128'(busy4), 128'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_rst_no_dv", 128'(dv4), 128'd0);
        end
        req4("post_rst", 32'h0000_0020, L2);

        // Latency 1: alternating lines on alternate cycles.
        for (int i = 0; i < 4; i++) begin
            rd1 = 1'b1;
            pc1 = (i % 2 == 1) ? 32'h0000_0010 : 32'h0000_0000;
            tick();
            rd1 = 1'b0;
            chk("l1_dv_on", 128'(dv1), 128'd1);
            chk("l1_dout", dout1, (i % 2 == 1) ? L1 : L0);
            tick();
            chk("l1_dv_off", 128'(dv1), 128'd0);
        end
        rd1 = 1'b1;
        ab1 = 1'b1;
        pc1 = 32'h0000_0050;
        tick();
        rd1 = 1'b0;
        ab1 = 1'b0;
        chk("l1_abort_dv", 128'(dv1), 128'd0);
        chk("l1_abort_dout", dout1, L1);
        tick();
        chk("l1_abort_dv2", 128'(dv1), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
